// File: rtl/apb3_bridge_decoder_if.sv
// ============================================================================
// Module      : apb3_bridge_decoder_if
// Description : Bus bundle for the pipelined-memory-bus to APB3 bridge/decoder
//               (CPU command/response side plus the shared APB3 side).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb3_bridge_decoder_if #(
    parameter int SLAVE_COUNT = 6,
    parameter int ADDR_WIDTH  = 20
);
    logic                          io_pipelinedMemoryBus_cmd_valid;
    logic                          io_pipelinedMemoryBus_cmd_ready;
    logic                          io_pipelinedMemoryBus_cmd_payload_write;
    logic [31:0]                   io_pipelinedMemoryBus_cmd_payload_address;
    logic [31:0]                   io_pipelinedMemoryBus_cmd_payload_data;
    logic [3:0]                    io_pipelinedMemoryBus_cmd_payload_mask;
    logic                          io_pipelinedMemoryBus_rsp_valid;
    logic [31:0]                   io_pipelinedMemoryBus_rsp_payload_data;
    logic                          io_pipelinedMemoryBus_rsp_payload_error;

    logic [ADDR_WIDTH-1:0]         io_apb_PADDR;
    logic [SLAVE_COUNT-1:0]        io_apb_PSEL;
    logic                          io_apb_PENABLE;
    logic                          io_apb_PWRITE;
    logic [31:0]                   io_apb_PWDATA;
    logic [3:0]                    io_apb_PSTRB;
    logic [SLAVE_COUNT-1:0]        io_apb_PREADY;
    logic [SLAVE_COUNT-1:0]        io_apb_PSLVERROR;
    logic [32*SLAVE_COUNT-1:0]     io_apb_PRDATA;

    // Bridge view
    modport slave (
        input  io_pipelinedMemoryBus_cmd_valid,
        output io_pipelinedMemoryBus_cmd_ready,
        input  io_pipelinedMemoryBus_cmd_payload_write,
        input  io_pipelinedMemoryBus_cmd_payload_address,
        input  io_pipelinedMemoryBus_cmd_payload_data,
        input  io_pipelinedMemoryBus_cmd_payload_mask,
        output io_pipelinedMemoryBus_rsp_valid,
        output io_pipelinedMemoryBus_rsp_payload_data,
        output io_pipelinedMemoryBus_rsp_payload_error,
        output io_apb_PADDR,
        output io_apb_PSEL,
        output io_apb_PENABLE,
        output io_apb_PWRITE,
        output io_apb_PWDATA,
        output io_apb_PSTRB,
        input  io_apb_PREADY,
        input  io_apb_PSLVERROR,
        input  io_apb_PRDATA
    );

    // CPU + peripheral cluster view
    modport master (
        output io_pipelinedMemoryBus_cmd_valid,
        input  io_pipelinedMemoryBus_cmd_ready,
        output io_pipelinedMemoryBus_cmd_payload_write,
        output io_pipelinedMemoryBus_cmd_payload_address,
        output io_pipelinedMemoryBus_cmd_payload_data,
        output io_pipelinedMemoryBus_cmd_payload_mask,
        input  io_pipelinedMemoryBus_rsp_valid,
        input  io_pipelinedMemoryBus_rsp_payload_data,
        input  io_pipelinedMemoryBus_rsp_payload_error,
        input  io_apb_PADDR,
        input  io_apb_PSEL,
        input  io_apb_PENABLE,
        input  io_apb_PWRITE,
        input  io_apb_PWDATA,
        input  io_apb_PSTRB,
        output io_apb_PREADY,
        output io_apb_PSLVERROR,
        output io_apb_PRDATA
    );
endinterface

`default_nettype wire

// File: rtl/apb3_bridge_decoder.sv
// ============================================================================
// Module      : apb3_bridge_decoder
// Description : Pipelined-memory-bus to APB3 master bridge with N-slave slot
//               decoder, response mux and PSTRB forwarding. Optional PREADY
//               timeout enabled by defining APB3_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb3_bridge_decoder #(
    parameter int SLAVE_COUNT    = 6,
    parameter int ADDR_WIDTH     = 20,
    parameter int SEL_LO         = 16,
    parameter int SLOT_BASE      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic             io_mainClk,
    input  wire logic             resetCtrl_systemReset,
    apb3_bridge_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   buf_valid_q;
    logic                   write_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [31:0]            data_q;
    logic [3:0]             mask_q;
    logic [3:0]             idx_q;
    logic                   hit_q;
    logic                   rsp_valid_q;
    logic [31:0]            rsp_data_q;
    logic                   rsp_error_q;

    logic                   w_accept;
    logic [3:0]             w_slot;
    logic [5:0]             w_slot_ext;
    logic                   w_hit;
    logic [3:0]             w_idx;
    logic [SLAVE_COUNT-1:0] w_psel;
    logic                   w_penable;
    logic                   w_complete;
    logic                   w_cpl_error;
    logic [31:0]            w_cpl_data;
    logic                   w_sel_ready;
    logic                   w_sel_error;
    logic [31:0]            w_sel_rdata;
    logic                   w_timeout;
    logic                   w_unused_addr;

    assign w_accept      = bus.io_pipelinedMemoryBus_cmd_valid && !buf_valid_q;
    assign w_slot        = bus.io_pipelinedMemoryBus_cmd_payload_address[SEL_LO+3:SEL_LO];
    assign w_slot_ext    = {2'b00, w_slot};
    assign w_hit         = (w_slot_ext >= 6'(SLOT_BASE)) &&
                           (w_slot_ext <  6'(SLOT_BASE + SLAVE_COUNT));
    assign w_idx         = w_slot - 4'(SLOT_BASE);
    assign w_unused_addr = ^bus.io_pipelinedMemoryBus_cmd_payload_address;

    // Response mux: only the addressed slave's PREADY/PSLVERROR/PRDATA matter
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_error = 1'b0;
        w_sel_rdata = 32'h0;
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            if (idx_q == i[3:0]) begin
                w_sel_ready = bus.io_apb_PREADY[i];
                w_sel_error = bus.io_apb_PSLVERROR[i];
                w_sel_rdata = bus.io_apb_PRDATA[i*32 +: 32];
            end
        end
    end

`ifdef APB3_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    // Fires in the ACCESS cycle that brings the count of ACCESS cycles to the limit
    assign w_timeout = (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES));
    assign cnt_d     = ((state_q == S_ACCESS) && (state_d == S_ACCESS)) ? cnt_q + 16'd1 : 16'd0;

    always_ff @(posedge io_mainClk) begin
        if (resetCtrl_systemReset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic w_unused_cfg;
    assign w_timeout    = 1'b0;
    assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d     = state_q;
        w_psel      = '0;
        w_penable   = 1'b0;
        w_complete  = 1'b0;
        w_cpl_error = 1'b0;
        w_cpl_data  = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (buf_valid_q || w_accept) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (hit_q) begin
                    w_psel  = SLAVE_COUNT'(1) << idx_q;
                    state_d = S_ACCESS;
                end else begin
                    w_complete  = 1'b1;
                    w_cpl_error = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_ACCESS: begin
                w_psel    = SLAVE_COUNT'(1) << idx_q;
                w_penable = 1'b1;
                if (w_sel_ready) begin
                    w_complete  = 1'b1;
                    w_cpl_error = w_sel_error;
                    w_cpl_data  = w_sel_error ? 32'h0 : w_sel_rdata;
                    state_d     = S_IDLE;
                end else if (w_timeout) begin
                    w_complete  = 1'b1;
                    w_cpl_error = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge io_mainClk) begin
        if (resetCtrl_systemReset) begin
            state_q     <= S_IDLE;
            buf_valid_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= 32'h0;
            mask_q      <= 4'h0;
            idx_q       <= 4'h0;
            hit_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                buf_valid_q <= 1'b1;
                write_q     <= bus.io_pipelinedMemoryBus_cmd_payload_write;
                addr_q      <= bus.io_pipelinedMemoryBus_cmd_payload_address[ADDR_WIDTH-1:0];
                data_q      <= bus.io_pipelinedMemoryBus_cmd_payload_data;
                mask_q      <= bus.io_pipelinedMemoryBus_cmd_payload_mask;
                idx_q       <= w_idx;
                hit_q       <= w_hit;
            end else if (w_complete) begin
                buf_valid_q <= 1'b0;
            end
            // Writes complete silently, including their errors
            rsp_valid_q <= w_complete && !write_q;
            if (w_complete && !write_q) begin
                rsp_data_q  <= w_cpl_data;
                rsp_error_q <= w_cpl_error;
            end
        end
    end

    assign bus.io_pipelinedMemoryBus_cmd_ready         = !buf_valid_q;
    assign bus.io_pipelinedMemoryBus_rsp_valid         = rsp_valid_q;
    assign bus.io_pipelinedMemoryBus_rsp_payload_data  = rsp_data_q;
    assign bus.io_pipelinedMemoryBus_rsp_payload_error = rsp_error_q;
    assign bus.io_apb_PADDR                            = addr_q;
    assign bus.io_apb_PSEL                             = w_psel;
    assign bus.io_apb_PENABLE                          = w_penable;
    assign bus.io_apb_PWRITE                           = write_q;
    assign bus.io_apb_PWDATA                           = data_q;
    assign bus.io_apb_PSTRB                            = write_q ? mask_q : 4'h0;

endmodule

`default_nettype wire

// File: tb/tb_apb3_bridge_decoder.sv
// ============================================================================
// Module      : tb_apb3_bridge_decoder
// Description : Self-checking bench for apb3_bridge_decoder; directed and
//               random transactions against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb3_bridge_decoder;

    localparam int SLAVE_COUNT    = 6;
    localparam int ADDR_WIDTH     = 20;
    localparam int SEL_LO         = 16;
    localparam int SLOT_BASE      = 3;
    localparam int TIMEOUT_CYCLES = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic        cfg_stuck;
    logic        cfg_err;
    int          cfg_wait;
    logic [31:0] cfg_rdata;
    int          acc;

    logic [SLAVE_COUNT-1:0]    slv_ready;
    logic [SLAVE_COUNT-1:0]    slv_err;
    logic [32*SLAVE_COUNT-1:0] slv_rdata;

    apb3_bridge_decoder_if #(.SLAVE_COUNT(SLAVE_COUNT), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    apb3_bridge_decoder #(
        .SLAVE_COUNT   (SLAVE_COUNT),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .SEL_LO        (SEL_LO),
        .SLOT_BASE     (SLOT_BASE),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .io_mainClk           (clk),
        .resetCtrl_systemReset(rst),
        .bus                  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave cluster: selected slave answers per cfg_*, others drive junk
    always @(posedge clk) acc <= bus.io_apb_PENABLE ? acc + 1 : 0;

    always_comb begin
        slv_ready = '0;
        slv_err   = '0;
        slv_rdata = '0;
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            if (bus.io_apb_PSEL[i] && bus.io_apb_PENABLE) begin
                slv_ready[i]         = !cfg_stuck && (acc == cfg_wait);
                slv_err[i]           = cfg_err;
                slv_rdata[i*32 +: 32] = cfg_rdata;
            end else begin
                slv_ready[i]         = 1'b1;
                slv_err[i]           = 1'b1;
                slv_rdata[i*32 +: 32] = ~cfg_rdata;
            end
        end
    end

    assign bus.io_apb_PREADY    = slv_ready;
    assign bus.io_apb_PSLVERROR = slv_err;
    assign bus.io_apb_PRDATA    = slv_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction; expected behaviour derived from the address slot rules
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input int wt, input logic err,
                       input logic [31:0] rd, input logic stuck);
        int                     slot;
        logic                   hit;
        logic [SLAVE_COUNT-1:0] exp_sel;
        logic                   exp_err;
        logic [31:0]            exp_data;
        logic [3:0]             exp_strb;
        int                     n;

        slot     = int'(addr[SEL_LO+3 -: 4]);
        hit      = (slot >= SLOT_BASE) && (slot < SLOT_BASE + SLAVE_COUNT);
        exp_sel  = hit ? (SLAVE_COUNT'(1) << (slot - SLOT_BASE)) : '0;
        exp_strb = wr ? mask : 4'h0;
        exp_err  = !hit || stuck || err;
        exp_data = exp_err ? 32'h0 : rd;
        n        = stuck ? TIMEOUT_CYCLES : wt + 1;

        @(negedge clk);
        cfg_stuck = stuck;
        cfg_err   = err;
        cfg_wait  = wt;
        cfg_rdata = rd;
        bus.io_pipelinedMemoryBus_cmd_valid         = 1'b1;
        bus.io_pipelinedMemoryBus_cmd_payload_write = wr;
        bus.io_pipelinedMemoryBus_cmd_payload_address = addr;
        bus.io_pipelinedMemoryBus_cmd_payload_data  = data;
        bus.io_pipelinedMemoryBus_cmd_payload_mask  = mask;
        check("cmd_ready_idle", 64'(bus.io_pipelinedMemoryBus_cmd_ready), 64'(1));

        @(negedge clk);
        bus.io_pipelinedMemoryBus_cmd_valid           = 1'b0;
        bus.io_pipelinedMemoryBus_cmd_payload_address = $urandom;
        bus.io_pipelinedMemoryBus_cmd_payload_data    = $urandom;
        check("setup_psel",    64'(bus.io_apb_PSEL),    64'(exp_sel));
        check("setup_penable", 64'(bus.io_apb_PENABLE), 64'(0));
        check("setup_paddr",   64'(bus.io_apb_PADDR),   64'(addr[ADDR_WIDTH-1:0]));
        check("setup_pwrite",  64'(bus.io_apb_PWRITE),  64'(wr));
        check("setup_pwdata",  64'(bus.io_apb_PWDATA),  64'(data));
        check("setup_pstrb",   64'(bus.io_apb_PSTRB),   64'(exp_strb));
        check("setup_ready",   64'(bus.io_pipelinedMemoryBus_cmd_ready), 64'(0));
        check("setup_rspv",    64'(bus.io_pipelinedMemoryBus_rsp_valid), 64'(0));

        if (hit) begin
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                check("acc_psel",    64'(bus.io_apb_PSEL),    64'(exp_sel));
                check("acc_penable", 64'(bus.io_apb_PENABLE), 64'(1));
                check("acc_paddr",   64'(bus.io_apb_PADDR),   64'(addr[ADDR_WIDTH-1:0]));
                check("acc_pstrb",   64'(bus.io_apb_PSTRB),   64'(exp_strb));
                check("acc_pwdata",  64'(bus.io_apb_PWDATA),  64'(data));
                check("acc_rspv",    64'(bus.io_pipelinedMemoryBus_rsp_valid), 64'(0));
            end
        end

        @(negedge clk);
        check("done_rspv",    64'(bus.io_pipelinedMemoryBus_rsp_valid), 64'(!wr));
        if (!wr) begin
            check("done_rsp_data", 64'(bus.io_pipelinedMemoryBus_rsp_payload_data),  64'(exp_data));
            check("done_rsp_err",  64'(bus.io_pipelinedMemoryBus_rsp_payload_error), 64'(exp_err));
        end
        check("done_ready",   64'(bus.io_pipelinedMemoryBus_cmd_ready), 64'(1));
        check("done_psel",    64'(bus.io_apb_PSEL),    64'(0));
        check("done_penable", 64'(bus.io_apb_PENABLE), 64'(0));

        @(negedge clk);
        check("post_rspv", 64'(bus.io_pipelinedMemoryBus_rsp_valid), 64'(0));
    endtask

    initial begin
        logic        r_wr;
        logic [31:0] r_addr;
        checks    = 0;
        errors    = 0;
        cfg_stuck = 1'b0;
        cfg_err   = 1'b0;
        cfg_wait  = 0;
        cfg_rdata = 32'h0;
        rst       = 1'b1;
        bus.io_pipelinedMemoryBus_cmd_valid           = 1'b0;
        bus.io_pipelinedMemoryBus_cmd_payload_write   = 1'b0;
        bus.io_pipelinedMemoryBus_cmd_payload_address = 32'h0;
        bus.io_pipelinedMemoryBus_cmd_payload_data    = 32'h0;
        bus.io_pipelinedMemoryBus_cmd_payload_mask    = 4'h0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 64'(bus.io_pipelinedMemoryBus_cmd_ready), 64'(1));
        check("rst_rsp_valid", 64'(bus.io_pipelinedMemoryBus_rsp_valid), 64'(0));
        check("rst_rsp_data",  64'(bus.io_pipelinedMemoryBus_rsp_payload_data), 64'(0));
        check("rst_rsp_err",   64'(bus.io_pipelinedMemoryBus_rsp_payload_error), 64'(0));
        check("rst_psel",      64'(bus.io_apb_PSEL),    64'(0));
        check("rst_penable",   64'(bus.io_apb_PENABLE), 64'(0));
        check("rst_pwrite",    64'(bus.io_apb_PWRITE),  64'(0));
        check("rst_paddr",     64'(bus.io_apb_PADDR),   64'(0));
        check("rst_pwdata",    64'(bus.io_apb_PWDATA),  64'(0));
        check("rst_pstrb",     64'(bus.io_apb_PSTRB),   64'(0));

        txn(1'b0, 32'h0005_0004, 32'h0,         4'hF,    0, 1'b0, 32'hA5A5_1234, 1'b0);
        txn(1'b1, 32'h0003_0010, 32'hCAFE_F00D, 4'b0011, 3, 1'b0, 32'h0,         1'b0);
        txn(1'b0, 32'h0000_0000, 32'h0,         4'hF,    0, 1'b0, 32'h1234_5678, 1'b0);
        txn(1'b0, 32'h0008_0000, 32'h0,         4'hF,    0, 1'b1, 32'h0000_0001, 1'b0);
        txn(1'b0, 32'h000F_0000, 32'h0,         4'hF,    0, 1'b0, 32'h5555_AAAA, 1'b0);
        txn(1'b1, 32'h0002_0000, 32'h1111_2222, 4'hF,    1, 1'b0, 32'h0,         1'b0);

`ifdef APB3_TIMEOUT_EN
        txn(1'b0, 32'h0004_0000, 32'h0, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        txn(1'b0, 32'h0005_0000, 32'h0, 4'hF, 0, 1'b0, 32'h0BAD_CAFE, 1'b0);
`endif

        // Reset for one cycle in the middle of an ACCESS phase
        @(negedge clk);
        cfg_stuck = 1'b0;
        cfg_err   = 1'b0;
        cfg_wait  = 5;
        cfg_rdata = 32'h7777_7777;
        bus.io_pipelinedMemoryBus_cmd_valid           = 1'b1;
        bus.io_pipelinedMemoryBus_cmd_payload_write   = 1'b0;
        bus.io_pipelinedMemoryBus_cmd_payload_address = 32'h0005_0000;
        @(negedge clk);
        bus.io_pipelinedMemoryBus_cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_penable", 64'(bus.io_apb_PENABLE), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_psel",    64'(bus.io_apb_PSEL),    64'(0));
        check("mrst_penable", 64'(bus.io_apb_PENABLE), 64'(0));
        check("mrst_ready",   64'(bus.io_pipelinedMemoryBus_cmd_ready), 64'(1));
        check("mrst_rspv",    64'(bus.io_pipelinedMemoryBus_rsp_valid), 64'(0));
        check("mrst_paddr",   64'(bus.io_apb_PADDR),   64'(0));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("mrst_quiet_rspv", 64'(bus.io_pipelinedMemoryBus_rsp_valid), 64'(0));
            check("mrst_quiet_psel", 64'(bus.io_apb_PSEL), 64'(0));
        end

        for (int t = 0; t < 40; t++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = $urandom;
            txn(r_wr, r_addr, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
